btb_param: RTL
==============

Name: btb_param

Overview:
- Parametrised successor to the fixed branch target buffer in the fetch path.
- Direct-mapped, configurable depth, with N-bit saturating-counter direction prediction per entry.
- Allocates on taken branches, flushes in one cycle, and keeps saturating performance counters for benchmarking runs.
- Fetch stage does the lookup combinationally in the same cycle; execute stage updates it when branches resolve.

Parameters:
- XLEN, 32, width of PC and target addresses.
- ENTRIES, 16, number of entries; power of 2, minimum 2.
- COUNTER_BITS, 2, width of each saturating direction counter; minimum 1.
- PERF_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  invalidate all entries.
- lookup_en  in  1  fetch lookup valid this cycle; gates performance counting only.
- pc  in  XLEN  fetch PC.
- target_pc  out  XLEN  predicted target.
- valid  out  1  lookup hit.
- predicted_taken  out  1  MSB of the hit entry's counter; 0 on miss.
- update  in  1  resolved control-flow instruction in EX.
- update_pc  in  XLEN  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_target  in  XLEN  computed target.
- mispredicted  in  1  EX redirect occurred.
- perf_clear  in  1  zero all performance counters.
- perf_lookups  out  PERF_WIDTH  count of cycles with lookup_en=1.
- perf_hits  out  PERF_WIDTH  count of cycles with lookup_en=1 and valid=1.
- perf_mispredicts  out  PERF_WIDTH  count of cycles with update=1 and mispredicted=1.

Behaviour:
- Addressing:
  - IDX = log2(ENTRIES).
  - Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
  - update_pc is split the same way.
- Lookup is purely combinational (zero latency).
  - valid = entry valid AND tag match.
  - target_pc = stored target on hit, else 0.
  - predicted_taken = counter[COUNTER_BITS-1] AND hit.
- Update is synchronous, on the rising edge with update=1:
  - Hit, taken: counter increments, saturating at 2^COUNTER_BITS-1; target overwritten with update_target.
  - Hit, not taken: counter decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate/replace the indexed entry; valid=1, tag written, target=update_target, counter = 2^(COUNTER_BITS-1) (weakly taken).
  - Miss, not taken: no change.
- Aliasing: a different tag at the same index is a miss, so a taken update evicts the old entry.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. No bypass.
- flush=1 clears all valid bits at the next edge. Targets, tags and counters are not required to be cleared.
- flush and update in the same cycle: flush wins; no entry is valid afterwards.
- Reset (asserted asynchronously):
  - All valid bits and all performance counters become 0.
  - Outputs therefore read valid=0, predicted_taken=0, target_pc=0, perf_*=0.
  - Storage arrays need not be reset.
  - Reset mid-update discards the update.
- Performance counters:
  - Increment per cycle as defined in Ports and saturate at all-ones (no wrap).
  - perf_clear zeroes them at the next edge and takes priority over an increment in the same cycle.
  - flush does not affect them.
- mispredicted feeds only perf_mispredicts; all training uses update_taken.
- Storage: flops (no RAM macro), so single-cycle flush is possible.

Decomposition:
- Shared package btb_pkg holds:
  - function clog2;
  - localparams for the counter init value (2^(COUNTER_BITS-1)) and max (2^COUNTER_BITS-1);
  - function sat_update(counter, taken).
- One sub-module is natural: btb_perf_counter, a saturating counter with clear and increment, instantiated three times.

Test Plan (ENTRIES=16, COUNTER_BITS=2):
- Reset then lookup pc=0x40 -> valid=0, predicted_taken=0, target_pc=0; all perf counters 0.
- Update pc=0x40, taken=1, target=0x100; lookup 0x40 next cycle -> valid=1, target_pc=0x100, predicted_taken=1 (counter 2).
- On the 0x40 entry, not-taken updates (a) twice, then (b) once more -> (a) counter 0, predicted_taken=0, valid=1; (b) counter stays 0. Then three taken updates -> counter 3; a fourth taken update -> stays 3.
- Alias: entry 0x40 valid, then update pc=0x80 taken target=0x200 -> lookup 0x40 valid=0; lookup 0x80 valid=1, target_pc=0x200.
- flush=1 asserted together with update pc=0x44 taken -> next cycle lookups of 0x40 and 0x44 both valid=0.
- 5 lookup cycles with 3 hits plus 2 mispredicted updates -> perf_lookups=5, perf_hits=3, perf_mispredicts=2. perf_clear -> all 0. Force perf_lookups to all-ones and look up again -> value holds at all-ones.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the parametrised branch target buffer.
// Counter helpers take the counter width as an argument so one package serves every instance.
package btb_pkg;

    localparam int DEFAULT_COUNTER_BITS = 2;
    localparam int unsigned DEFAULT_CTR_INIT = 2 ** (DEFAULT_COUNTER_BITS - 1);
    localparam int unsigned DEFAULT_CTR_MAX  = 2 ** DEFAULT_COUNTER_BITS - 1;

    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ctr_init(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

    function automatic int unsigned ctr_max(input int bits);
        return 32'((64'd1 << bits) - 64'd1);
    endfunction

    // Saturating up/down step of a direction counter of the given width.
    function automatic logic [31:0] sat_update(input logic [31:0] counter, input logic taken,
                                               input int bits);
        logic [31:0] max_v;
        max_v = ctr_max(bits);
        if (taken) begin
            return (counter >= max_v) ? max_v : counter + 32'd1;
        end
        return (counter == 32'd0) ? 32'd0 : counter - 32'd1;
    endfunction

endpackage

// File: rtl/btb_perf_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module btb_perf_counter
    import btb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/btb_param.sv
// Direct-mapped branch target buffer with saturating direction counters,
// zero-latency lookup, single-cycle flush and saturating performance counters.
module btb_param
    import btb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int PERF_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  lookup_en,
    input  logic [XLEN-1:0]       pc,
    output logic [XLEN-1:0]       target_pc,
    output logic                  valid,
    output logic                  predicted_taken,
    input  logic                  update,
    input  logic [XLEN-1:0]       update_pc,
    input  logic                  update_taken,
    input  logic [XLEN-1:0]       update_target,
    input  logic                  mispredicted,
    input  logic                  perf_clear,
    output logic [PERF_WIDTH-1:0] perf_lookups,
    output logic [PERF_WIDTH-1:0] perf_hits,
    output logic [PERF_WIDTH-1:0] perf_mispredicts
);

    localparam int IDX   = clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [COUNTER_BITS-1:0] CTR_INIT = COUNTER_BITS'(ctr_init(COUNTER_BITS));

    logic [ENTRIES-1:0]      valid_q;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [XLEN-1:0]         target_q [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]          lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic [IDX-1:0]          up_idx;
    logic [TAG_W-1:0]        up_tag;
    logic                    lk_hit;
    logic                    up_hit;
    logic [COUNTER_BITS-1:0] ctr_next;
    logic [31:0]             ctr_wide;
    logic                    unused_bits;

    assign lk_idx = pc[IDX+1:2];
    assign lk_tag = pc[XLEN-1:IDX+2];
    assign up_idx = update_pc[IDX+1:2];
    assign up_tag = update_pc[XLEN-1:IDX+2];
    assign unused_bits = ^{pc[1:0], update_pc[1:0], ctr_wide};

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign valid           = lk_hit;
    assign target_pc       = lk_hit ? target_q[lk_idx] : '0;
    assign predicted_taken = lk_hit & ctr_q[lk_idx][COUNTER_BITS-1];

    assign ctr_wide = sat_update(32'(ctr_q[up_idx]), update_taken, COUNTER_BITS);
    assign ctr_next = ctr_wide[COUNTER_BITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (update && update_taken && !up_hit) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Payload flops carry no reset; a write landing during reset or flush stays invisible
    // because the matching valid bit is cleared on the same edge.
    always_ff @(posedge clk) begin
        if (update && !flush) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next;
                if (update_taken) begin
                    target_q[up_idx] <= update_target;
                end
            end else if (update_taken) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                ctr_q[up_idx]    <= CTR_INIT;
            end
        end
    end

    btb_perf_counter #(.WIDTH(PERF_WIDTH)) u_perf_lookups (
        .clk   (clk),
        .rst   (rst),
        .clear (perf_clear),
        .inc   (lookup_en),
        .count (perf_lookups)
    );

    btb_perf_counter #(.WIDTH(PERF_WIDTH)) u_perf_hits (
        .clk   (clk),
        .rst   (rst),
        .clear (perf_clear),
        .inc   (lookup_en & lk_hit),
        .count (perf_hits)
    );

    btb_perf_counter #(.WIDTH(PERF_WIDTH)) u_perf_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .clear (perf_clear),
        .inc   (update & mispredicted),
        .count (perf_mispredicts)
    );

endmodule
